// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
//   state_e  : arbiter FSM states (IDLE, BUSY, DONE)
//   op_e     : latched memory operation (RD, WR)
//   req_id_t : requester index (0 or 1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  typedef logic req_id_t;

  // A requester is active when either strobe is high.
  function automatic logic has_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

  // Write wins when rd and wr are raised together.
  function automatic op_e decode_op(input logic wr);
    return wr ? WR : RD;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin decision, purely combinational.
// Ports:
//   req[1:0]   : active requests (bit n = requester n)
//   last_grant : requester granted most recently
//   grant_id   : selected requester (meaningful when valid)
//   valid      : at least one request is active
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output req_id_t    grant_id,
  output logic       valid
);

  // On a tie the requester not granted last time wins.
  always_comb begin
    valid    = |req;
    grant_id = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between two requesters.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles without ready_mem (ack + err pulse); otherwise the
// err outputs are tied low and BUSY waits indefinitely.
// Ports:
//   clock, reset_n                  : clock, async active-low reset
//   rd_reqN/wr_reqN/addr_reqN/wdata_reqN : requester N command
//   rdata_reqN/ack_reqN/err_reqN    : requester N response (registered)
//   rd_mem/wr_mem/addr_mem/wdata_mem: memory command (registered)
//   rdata_mem/ready_mem             : memory response
//   grant_id, busy                  : current owner, FSM not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH         = 9,
  parameter int unsigned DWIDTH         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req0,
  input  logic              wr_req0,
  input  logic              rd_req1,
  input  logic              wr_req1,
  input  logic [AWIDTH-1:0] addr_req0,
  input  logic [AWIDTH-1:0] addr_req1,
  input  logic [DWIDTH-1:0] wdata_req0,
  input  logic [DWIDTH-1:0] wdata_req1,
  output logic [DWIDTH-1:0] rdata_req0,
  output logic [DWIDTH-1:0] rdata_req1,
  output logic              ack_req0,
  output logic              ack_req1,
  output logic              err_req0,
  output logic              err_req1,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] wdata_mem,
  input  logic [DWIDTH-1:0] rdata_mem,
  input  logic              ready_mem,
  output logic              grant_id,
  output logic              busy
);

  state_e              state_q, state_d;
  req_id_t             last_grant_q, last_grant_d;
  op_e                 op_q, op_d;
  req_id_t             grant_d;
  logic                busy_d, rd_mem_d, wr_mem_d;
  logic                ack0_d, ack1_d;
  logic [AWIDTH-1:0]   addr_d;
  logic [DWIDTH-1:0]   wdata_d, rdata0_d, rdata1_d;

  logic [1:0]          req_vec;
  req_id_t             arb_grant;
  logic                arb_valid;
  op_e                 sel_op;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err0_d, err1_d;
`endif

  assign req_vec = {has_req(rd_req1, wr_req1), has_req(rd_req0, wr_req0)};

  rr_arbiter2 u_rr (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .grant_id   (arb_grant),
    .valid      (arb_valid)
  );

  // Command of the requester the arbiter would grant this cycle.
  always_comb begin
    if (arb_grant) begin
      sel_op    = decode_op(wr_req1);
      sel_addr  = addr_req1;
      sel_wdata = wdata_req1;
    end else begin
      sel_op    = decode_op(wr_req0);
      sel_addr  = addr_req0;
      sel_wdata = wdata_req0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    grant_d      = grant_id;
    rd_mem_d     = 1'b0;
    wr_mem_d     = 1'b0;
    addr_d       = addr_mem;
    wdata_d      = wdata_mem;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata_req0;
    rdata1_d     = rdata_req1;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d      = BUSY;
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          op_d         = sel_op;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          rd_mem_d     = (sel_op == RD);
          wr_mem_d     = (sel_op == WR);
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      BUSY: begin
        rd_mem_d = (op_q == RD);
        wr_mem_d = (op_q == WR);
        if (ready_mem) begin
          state_d  = DONE;
          rd_mem_d = 1'b0;
          wr_mem_d = 1'b0;
          if (grant_id) begin
            ack1_d = 1'b1;
            if (op_q == RD) rdata1_d = rdata_mem;
          end else begin
            ack0_d = 1'b1;
            if (op_q == RD) rdata0_d = rdata_mem;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog abort: complete with error, read data left untouched.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = DONE;
          rd_mem_d = 1'b0;
          wr_mem_d = 1'b0;
          if (grant_id) begin
            ack1_d = 1'b1;
            err1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
            err0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset prefers requester 0 on the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= RD;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      rd_mem       <= 1'b0;
      wr_mem       <= 1'b0;
      addr_mem     <= '0;
      wdata_mem    <= '0;
      ack_req0     <= 1'b0;
      ack_req1     <= 1'b0;
      rdata_req0   <= '0;
      rdata_req1   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      grant_id     <= grant_d;
      busy         <= busy_d;
      rd_mem       <= rd_mem_d;
      wr_mem       <= wr_mem_d;
      addr_mem     <= addr_d;
      wdata_mem    <= wdata_d;
      ack_req0     <= ack0_d;
      ack_req1     <= ack1_d;
      rdata_req0   <= rdata0_d;
      rdata_req1   <= rdata1_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog counter and error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      err_req0 <= 1'b0;
      err_req1 <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_req0 <= err0_d;
      err_req1 <= err1_d;
    end
  end
`else
  assign err_req0 = 1'b0;
  assign err_req1 = 1'b0;
`endif

endmodule
